// File: rtl/wrr_req_tracker.sv
// wrr_req_tracker: per-requester pending-request counters feeding a
// weighted round-robin arbiter. Each requester owns a saturating-free
// CNT_W-bit counter that is incremented by accepted pushes and decremented
// by valid grants. Invalid grants raise a sticky protocol-error flag.
//
// Optional feature macro: WRR_REQ_TRACKER_GNT_CNT_EN
//   defined   -> 16-bit saturating count of accepted grants on gnt_cnt
//   undefined -> gnt_cnt tied to zero, gnt_cnt_clr ignored, no counter flops
//
// Assumes N >= 2 so that ID_BITS is at least one bit wide.
module wrr_req_tracker #(
  parameter int N       = 32,
  parameter int CNT_W   = 4,
  parameter int ID_BITS = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       push,
  output logic [N-1:0]       push_rdy,
  output logic [N-1:0]       req,
  input  logic [N-1:0]       gnt_w,
  input  logic               ack,
  output logic [N*CNT_W-1:0] pend_cnt,
  output logic               gnt_err,
  output logic [15:0]        gnt_cnt,
  input  logic               gnt_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             gnt_err_q;
  logic             gnt_err_d;

  logic [N-1:0]       push_acc;
  logic [N-1:0]       pop_vec;
  logic [ID_BITS-1:0] gnt_idx;
  logic               gnt_onehot;
  logic               gnt_hit;
  logic               grant_ok;

  // Status outputs come purely from the counter registers, never from ack/gnt_w
  always_comb begin
    push_rdy = '0;
    req      = '0;
    pend_cnt = '0;
    for (int i = 0; i < N; i++) begin
      push_rdy[i]              = (cnt_q[i] != CNT_MAX);
      req[i]                   = (cnt_q[i] != '0);
      pend_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Encode the grant to an index and qualify it: exactly one bit set and that requester pending
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_w[i]) begin
        gnt_idx = ID_BITS'(i);
      end
    end
    gnt_onehot = (gnt_w != '0) && ((gnt_w & (gnt_w - N'(1))) == '0);
    gnt_hit    = req[gnt_idx];
    grant_ok   = ack & gnt_onehot & gnt_hit;
    pop_vec    = grant_ok ? gnt_w : '0;
    push_acc   = push & push_rdy;
  end

  // Next counter values: push and pop on the same requester cancel out
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push_acc[i] && !pop_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!push_acc[i] && pop_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Any acknowledged grant that is not a valid pop is a protocol error; the flag sticks
  always_comb begin
    gnt_err_d = gnt_err_q | (ack & ~grant_ok);
  end

  // Counter and error-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      gnt_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gnt_err_q <= gnt_err_d;
    end
  end

  assign gnt_err = gnt_err_q;

`ifdef WRR_REQ_TRACKER_GNT_CNT_EN
  logic [15:0] gnt_cnt_q;
  logic [15:0] gnt_cnt_d;

  // Grant statistics: clear wins over increment, increment saturates
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (gnt_cnt_clr) begin
      gnt_cnt_d = '0;
    end else if ((pop_vec != '0) && (gnt_cnt_q != 16'hFFFF)) begin
      gnt_cnt_d = gnt_cnt_q + 16'd1;
    end
  end

  // Grant statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt = gnt_cnt_q;
`else
  logic unused_gnt_cnt_clr;

  assign unused_gnt_cnt_clr = gnt_cnt_clr;
  assign gnt_cnt            = '0;
`endif

endmodule

// File: tb/tb_wrr_req_tracker.sv
// Directed self-checking bench for wrr_req_tracker (N=32, CNT_W=4).
// Honours WRR_REQ_TRACKER_GNT_CNT_EN when deciding the expected gnt_cnt.
module tb_wrr_req_tracker;

  localparam int N     = 32;
  localparam int CNT_W = 4;
`ifdef WRR_REQ_TRACKER_GNT_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     push;
  logic [N-1:0]     push_rdy;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt_w;
  logic             ack;
  logic [N*CNT_W-1:0] pend_cnt;
  logic             gnt_err;
  logic [15:0]      gnt_cnt;
  logic             gnt_cnt_clr;

  int checks = 0;
  int errors = 0;

  wrr_req_tracker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_rdy   (push_rdy),
    .req        (req),
    .gnt_w      (gnt_w),
    .ack        (ack),
    .pend_cnt   (pend_cnt),
    .gnt_err    (gnt_err),
    .gnt_cnt    (gnt_cnt),
    .gnt_cnt_clr(gnt_cnt_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance one cycle and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return pend_cnt[i*CNT_W +: CNT_W];
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = '0; gnt_w = '0; ack = 1'b0; gnt_cnt_clr = 1'b0;
    #2;
    checks++;
    if (req !== '0 || push_rdy !== '1 || pend_cnt !== '0 || gnt_err !== 1'b0 || gnt_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: req=%h rdy=%h pend=%h err=%b gc=%h required 0/all-ones/0/0/0",
               req, push_rdy, pend_cnt, gnt_err, gnt_cnt);
    end
    push = 32'hFFFF_FFFF;
    step(); step();
    checks++;
    if (req !== '0 || pend_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold: req=%h pend=%h required 0", req, pend_cnt);
    end
    push = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_push_pop();
    push = 32'h8; step(); push = '0;
    checks++;
    if (req !== 32'h8 || cnt_of(3) !== 4'd1) begin
      errors++;
      $display("[TB] FAIL push3: req=%h cnt3=%0d required 8/1", req, cnt_of(3));
    end
    ack = 1'b1; gnt_w = 32'h8; step(); ack = 1'b0; gnt_w = '0;
    checks++;
    if (req !== '0 || cnt_of(3) !== 4'd0 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pop3: req=%h cnt3=%0d err=%b required 0/0/0", req, cnt_of(3), gnt_err);
    end
    push = 32'h8000_0003; step(); push = '0;
    checks++;
    if (req !== 32'h8000_0003) begin
      errors++;
      $display("[TB] FAIL multi_push: req=%h required 80000003", req);
    end
    ack = 1'b1; gnt_w = 32'h8000_0000; step();
    checks++;
    if (req !== 32'h3) begin
      errors++;
      $display("[TB] FAIL pop31: req=%h required 3", req);
    end
    gnt_w = 32'h1; step();
    gnt_w = 32'h2; step();
    ack = 1'b0; gnt_w = '0;
    checks++;
    if (req !== '0 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_multi: req=%h err=%b required 0/0", req, gnt_err);
    end
  endtask

  task automatic test_ack_low();
    push = 32'h80; step(); push = '0;
    gnt_w = 32'h80; step();
    gnt_w = 32'h3; step();
    gnt_w = '0;
    checks++;
    if (cnt_of(7) !== 4'd1 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_low_ignored: cnt7=%0d err=%b required 1/0", cnt_of(7), gnt_err);
    end
    ack = 1'b1; gnt_w = 32'h80; step(); ack = 1'b0; gnt_w = '0;
  endtask

  task automatic test_saturation();
    push = 32'h1;
    repeat (15) step();
    checks++;
    if (cnt_of(0) !== 4'd15 || push_rdy[0] !== 1'b0 || push_rdy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill15: cnt0=%0d rdy=%h required 15, rdy[0]=0 rdy[1]=1", cnt_of(0), push_rdy);
    end
    step();
    checks++;
    if (cnt_of(0) !== 4'd15 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_push: cnt0=%0d err=%b required 15/0", cnt_of(0), gnt_err);
    end
    ack = 1'b1; gnt_w = 32'h1; step();
    push = '0;
    checks++;
    if (cnt_of(0) !== 4'd14 || push_rdy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pop: cnt0=%0d rdy0=%b required 14/1", cnt_of(0), push_rdy[0]);
    end
    repeat (14) step();
    ack = 1'b0; gnt_w = '0;
    checks++;
    if (req !== '0 || cnt_of(0) !== 4'd0 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain0: req=%h cnt0=%0d err=%b required 0/0/0", req, cnt_of(0), gnt_err);
    end
  endtask

  task automatic test_simultaneous();
    push = 32'h20; step(); step();
    checks++;
    if (cnt_of(5) !== 4'd2) begin
      errors++;
      $display("[TB] FAIL setup5: cnt5=%0d required 2", cnt_of(5));
    end
    ack = 1'b1; gnt_w = 32'h20; step();
    push = '0;
    checks++;
    if (cnt_of(5) !== 4'd2 || req[5] !== 1'b1 || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_pop_same: cnt5=%0d req5=%b err=%b required 2/1/0", cnt_of(5), req[5], gnt_err);
    end
    step();
    checks++;
    if (cnt_of(5) !== 4'd1 || req[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pop5_to1: cnt5=%0d req5=%b required 1/1", cnt_of(5), req[5]);
    end
    step();
    ack = 1'b0; gnt_w = '0;
    checks++;
    if (cnt_of(5) !== 4'd0 || req[5] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pop5_to0: cnt5=%0d req5=%b required 0/0", cnt_of(5), req[5]);
    end
  endtask

  task automatic test_gnt_cnt();
    pulse_reset();
    push = 32'h4; repeat (3) step(); push = '0;
    ack = 1'b1; gnt_w = 32'h4; repeat (3) step(); ack = 1'b0; gnt_w = '0;
    checks++;
    if (gnt_cnt !== (GC_EN ? 16'd3 : 16'd0) || cnt_of(2) !== 4'd0) begin
      errors++;
      $display("[TB] FAIL gnt_cnt3: gc=%0d cnt2=%0d required %0d/0", gnt_cnt, cnt_of(2), GC_EN ? 3 : 0);
    end
    push = 32'h4; step(); push = '0;
    ack = 1'b1; gnt_w = 32'h4; gnt_cnt_clr = 1'b1; step();
    gnt_cnt_clr = 1'b0;
    checks++;
    if (gnt_cnt !== 16'd0 || cnt_of(2) !== 4'd0) begin
      errors++;
      $display("[TB] FAIL gnt_cnt_clr: gc=%0d cnt2=%0d required 0/0", gnt_cnt, cnt_of(2));
    end
    ack = 1'b0; gnt_w = '0;
    push = 32'h4; step(); push = '0;
    ack = 1'b1; gnt_w = 32'h4; step(); ack = 1'b0; gnt_w = '0;
    checks++;
    if (gnt_cnt !== (GC_EN ? 16'd1 : 16'd0) || gnt_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gnt_cnt_after_clr: gc=%0d err=%b required %0d/0", gnt_cnt, gnt_err, GC_EN ? 1 : 0);
    end
  endtask

  task automatic test_error_and_mid_reset();
    pulse_reset();
    push = 32'h3; step(); push = '0;
    ack = 1'b1; gnt_w = 32'h3; step(); ack = 1'b0; gnt_w = '0;
    checks++;
    if (gnt_err !== 1'b1 || cnt_of(0) !== 4'd1 || cnt_of(1) !== 4'd1 || gnt_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL multihot_err: err=%b cnt0=%0d cnt1=%0d gc=%0d required 1/1/1/0",
               gnt_err, cnt_of(0), cnt_of(1), gnt_cnt);
    end
    repeat (100) step();
    checks++;
    if (gnt_err !== 1'b1 || req !== 32'h3) begin
      errors++;
      $display("[TB] FAIL err_sticky: err=%b req=%h required 1/3", gnt_err, req);
    end
    // Asynchronous reset between clock edges with counters nonzero
    push = 32'h200;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== '0 || push_rdy !== '1 || pend_cnt !== '0 || gnt_err !== 1'b0 || gnt_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: req=%h rdy=%h pend=%h err=%b gc=%h required 0/all-ones/0/0/0",
               req, push_rdy, pend_cnt, gnt_err, gnt_cnt);
    end
    step(); step();
    checks++;
    if (req !== '0) begin
      errors++;
      $display("[TB] FAIL reset_discard_push: req=%h required 0", req);
    end
    rst_n = 1'b1;
    step();
    push = '0;
    checks++;
    if (req !== 32'h200 || cnt_of(9) !== 4'd1) begin
      errors++;
      $display("[TB] FAIL resume: req=%h cnt9=%0d required 200/1", req, cnt_of(9));
    end
    // Grant to an empty requester
    ack = 1'b1; gnt_w = 32'h10; step(); ack = 1'b0; gnt_w = '0;
    checks++;
    if (gnt_err !== 1'b1 || cnt_of(4) !== 4'd0 || cnt_of(9) !== 4'd1) begin
      errors++;
      $display("[TB] FAIL empty_grant_err: err=%b cnt4=%0d cnt9=%0d required 1/0/1", gnt_err, cnt_of(4), cnt_of(9));
    end
    pulse_reset();
    // Zero grant vector with ack
    ack = 1'b1; gnt_w = '0; step(); ack = 1'b0;
    checks++;
    if (gnt_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_grant_err: err=%b required 1", gnt_err);
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_ack_low();
    test_saturation();
    test_simultaneous();
    test_gnt_cnt();
    test_error_and_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
